// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Sequencer for the R.O.E single-issue core. It owns the program counter,
// forwards the current instruction word to the combinational decoder, and
// stalls on data-memory operations until the memory acknowledges them. It
// redirects the PC on taken branches and stops when it fetches the halt word.
// The decoder's side effects are gated through commit_en.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   start        in   1      begin execution at PC 0 (honoured in IDLE or HALT)
//   instr        in   9      ROM data at address pc (combinational ROM)
//   mem_read     in   1      decoder: current instruction is LW
//   mem_write    in   1      decoder: current instruction is SW
//   branch_taken in   1      BNZ outcome for the current instruction
//   branch_tgt   in   PC_W   absolute branch target
//   mem_ack      in   1      data memory completed the access this cycle
//   pc           out  PC_W   instruction address
//   instr_out    out  9      instruction to decoder, 0 outside RUN/MEM_WAIT
//   commit_en    out  1      enables register/memory side effects this cycle
//   mem_req      out  1      data-memory request, held until mem_ack
//   done         out  1      high in HALT
//   err          out  1      sticky memory-timeout flag
//   cycles       out  CNT_W  saturating count of executing cycles
module fetch_sequencer #(
  parameter int         PC_W       = 10,
  parameter int         CNT_W      = 16,
  parameter logic [8:0] HALT_INSTR = 9'h1FF,
  parameter int         MEM_TMO    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_tgt,
  input  logic             mem_ack,
  output logic [PC_W-1:0]  pc,
  output logic [8:0]       instr_out,
  output logic             commit_en,
  output logic             mem_req,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  localparam int              WAIT_W    = $clog2(MEM_TMO + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TMO);
  localparam logic [PC_W-1:0]   PC_ONE    = PC_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT,
    HALT
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_op;
  logic              is_halt;
  logic [PC_W-1:0]   pc_inc;
  logic [CNT_W-1:0]  cycles_inc;

  // Decode helpers. The PC increment wraps naturally at 2^PC_W, and the cycle
  // counter sticks at its maximum value.
  always_comb begin
    mem_op     = mem_read | mem_write;
    is_halt    = (instr == HALT_INSTR);
    pc_inc     = pc + PC_ONE;
    cycles_inc = (cycles == CNT_MAX) ? cycles : cycles + CNT_ONE;
  end

  // The handshake outputs depend on this cycle's mem_ack, so they are
  // combinational. In RUN the halt word suppresses every side effect,
  // including any memory request its decode might imply.
  always_comb begin
    instr_out = '0;
    commit_en = 1'b0;
    mem_req   = 1'b0;
    case (state)
      RUN: begin
        instr_out = instr;
        if (!is_halt) begin
          if (mem_op) begin
            mem_req   = 1'b1;
            commit_en = mem_ack;
          end else begin
            commit_en = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        instr_out = instr;
        mem_req   = 1'b1;
        commit_en = mem_ack;
      end
      default: ;
    endcase
  end

  // Sequencer state, PC, status flags and cycle counter.
  // The cycle that decodes the halt word is not counted as an executing
  // cycle, so {ADD,ADD,HALT} reports two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      cycles   <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            pc     <= '0;
            cycles <= '0;
            err    <= 1'b0;
          end
        end
        RUN: begin
          if (is_halt) begin
            state <= HALT;
            done  <= 1'b1;
          end else begin
            cycles <= cycles_inc;
            if (mem_op) begin
              if (mem_ack) begin
                pc <= pc_inc;
              end else begin
                state    <= MEM_WAIT;
                wait_cnt <= WAIT_ONE;
              end
            end else begin
              pc <= branch_taken ? branch_tgt : pc_inc;
            end
          end
        end
        MEM_WAIT: begin
          cycles <= cycles_inc;
          if (mem_ack) begin
            pc    <= pc_inc;
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        HALT: begin
          if (start) begin
            state  <= RUN;
            pc     <= '0;
            cycles <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Drives fetch_sequencer from an instruction ROM that the bench owns. The bench
// keeps an instruction-level model of the program's progress, and every cycle
// it compares all outputs against that model. The run covers directed program
// scenarios, followed by randomized programs and handshakes. A second small
// instance (PC_W=3, CNT_W=3) shows PC wrap and counter saturation.
module tb_fetch_sequencer;

  localparam int PC_MOD  = 1024;
  localparam int CNT_MAX = 65535;
  localparam int MEM_TMO = 8;
  localparam int K_ALU   = 0;
  localparam int K_LW    = 1;
  localparam int K_SW    = 2;
  localparam int K_BNZ   = 3;
  localparam int K_HALT  = 4;

  logic        clk = 1'b0;
  logic        reset, start, mem_read, mem_write, branch_taken, mem_ack;
  logic [8:0]  instr;
  logic [9:0]  branch_tgt;
  logic [9:0]  pc;
  logic [8:0]  instr_out;
  logic        commit_en, mem_req, done, err;
  logic [15:0] cycles;

  logic        start2, zero2;
  logic [8:0]  instr2;
  logic [2:0]  tgt2;
  logic [2:0]  pc2;
  logic [8:0]  instr_out2;
  logic        commit_en2, mem_req2, done2, err2;
  logic [2:0]  cycles2;

  int rom_kind [PC_MOD];
  int cur_kind;

  int checks = 0;
  int errors = 0;
  int commits_seen, reqs_seen;

  // Reference view of the program's progress.
  bit m_active, m_done, m_err;
  int m_stall, m_pc, m_cycles;

  fetch_sequencer #(.PC_W(10), .CNT_W(16), .HALT_INSTR(9'h1FF), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .mem_read(mem_read), .mem_write(mem_write), .branch_taken(branch_taken),
    .branch_tgt(branch_tgt), .mem_ack(mem_ack), .pc(pc), .instr_out(instr_out),
    .commit_en(commit_en), .mem_req(mem_req), .done(done), .err(err), .cycles(cycles)
  );

  fetch_sequencer #(.PC_W(3), .CNT_W(3), .HALT_INSTR(9'h1FF), .MEM_TMO(MEM_TMO)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .instr(instr2),
    .mem_read(zero2), .mem_write(zero2), .branch_taken(zero2),
    .branch_tgt(tgt2), .mem_ack(zero2), .pc(pc2), .instr_out(instr_out2),
    .commit_en(commit_en2), .mem_req(mem_req2), .done(done2), .err(err2), .cycles(cycles2)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] word_of(int a);
    int k;
    k = rom_kind[a];
    if (k == K_HALT) return 9'h1FF;
    return {k[2:0], a[5:0]};
  endfunction

  // Combinational ROM and decoder seen by the DUT.
  always_comb begin
    cur_kind  = rom_kind[pc];
    instr     = (cur_kind == K_HALT) ? 9'h1FF : {cur_kind[2:0], pc[5:0]};
    mem_read  = (cur_kind == K_LW);
    mem_write = (cur_kind == K_SW);
  end

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(int k);
    for (int i = 0; i < PC_MOD; i++) rom_kind[i] = k;
  endtask

  // Advance the model by one clock, given this cycle's inputs.
  task automatic model_advance(bit rst, bit st, bit ack, bit tk, int tgt);
    int  k;
    bit  memop;
    k     = rom_kind[m_pc];
    memop = (k == K_LW) || (k == K_SW);
    if (rst) begin
      m_active = 0; m_stall = 0; m_done = 0; m_err = 0; m_pc = 0; m_cycles = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_pc = 0; m_cycles = 0; m_err = 0; m_done = 0; m_stall = 0;
      end
    end else if (m_stall > 0) begin
      m_cycles = (m_cycles < CNT_MAX) ? m_cycles + 1 : CNT_MAX;
      if (ack) begin
        m_pc = (m_pc + 1) % PC_MOD;
        m_stall = 0;
      end else if (m_stall == MEM_TMO) begin
        m_err = 1; m_done = 1; m_active = 0; m_stall = 0;
      end else begin
        m_stall++;
      end
    end else if (k == K_HALT) begin
      m_done = 1; m_active = 0;
    end else begin
      m_cycles = (m_cycles < CNT_MAX) ? m_cycles + 1 : CNT_MAX;
      if (memop) begin
        if (ack) m_pc = (m_pc + 1) % PC_MOD;
        else     m_stall = 1;
      end else begin
        m_pc = tk ? tgt : (m_pc + 1) % PC_MOD;
      end
    end
  endtask

  // Drive one cycle of inputs. Check every output against the model away from
  // the clock edge, then advance the model.
  task automatic applyStimulus(bit rst, bit st, bit ack, bit tk, int tgt);
    int k;
    bit e_commit, e_req;
    logic [8:0] e_iout;
    reset = rst; start = st; mem_ack = ack; branch_taken = tk; branch_tgt = tgt[9:0];
    @(negedge clk);
    k = rom_kind[m_pc];
    e_commit = 0; e_req = 0; e_iout = '0;
    if (m_active) begin
      e_iout = word_of(m_pc);
      if (m_stall > 0) begin
        e_req = 1; e_commit = ack;
      end else if (k == K_HALT) begin
        e_req = 0; e_commit = 0;
      end else if (k == K_LW || k == K_SW) begin
        e_req = 1; e_commit = ack;
      end else begin
        e_commit = 1;
      end
    end
    checkOutput("pc", 32'(pc), 32'(m_pc));
    checkOutput("cycles", 32'(cycles), 32'(m_cycles));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("err", 32'(err), 32'(m_err));
    checkOutput("commit_en", 32'(commit_en), 32'(e_commit));
    checkOutput("mem_req", 32'(mem_req), 32'(e_req));
    checkOutput("instr_out", 32'(instr_out), 32'(e_iout));
    commits_seen += int'(commit_en);
    reqs_seen    += int'(mem_req);
    model_advance(rst, st, ack, tk, tgt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit r_rst, r_st, r_ack, r_tk;
    int r_sel;
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0; branch_taken = 1'b0; branch_tgt = '0;
    start2 = 1'b0; zero2 = 1'b0; instr2 = 9'h000; tgt2 = 3'd0;
    m_active = 0; m_done = 0; m_err = 0; m_stall = 0; m_pc = 0; m_cycles = 0;
    commits_seen = 0; reqs_seen = 0;
    fill_rom(K_ALU);
    @(posedge clk);
    #1;

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_pc", 32'(pc), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);

    // Program {ADD, ADD, HALT}.
    rom_kind[2] = K_HALT;
    applyStimulus(0, 1, 0, 0, 0);
    commits_seen = 0;
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("halt_done", 32'(done), 32'd1);
    checkOutput("halt_cycles", 32'(cycles), 32'd2);
    checkOutput("halt_pc", 32'(pc), 32'd2);
    checkOutput("halt_commits", 32'(commits_seen), 32'd2);

    // LW at pc 4 is acknowledged after three wait cycles.
    fill_rom(K_ALU);
    rom_kind[4] = K_LW;
    rom_kind[5] = K_HALT;
    applyStimulus(0, 1, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0);
    commits_seen = 0; reqs_seen = 0;
    applyStimulus(0, 0, 0, 1, 9);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lw_pc_held", 32'(pc), 32'd4);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("lw_req_cycles", 32'(reqs_seen), 32'd4);
    checkOutput("lw_commits", 32'(commits_seen), 32'd1);
    checkOutput("lw_pc_after", 32'(pc), 32'd5);
    applyStimulus(0, 0, 0, 0, 0);

    // BNZ at pc 7: first taken to 2, then not taken.
    fill_rom(K_ALU);
    rom_kind[7] = K_BNZ;
    rom_kind[8] = K_HALT;
    applyStimulus(0, 1, 0, 0, 0);
    repeat (7) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2);
    checkOutput("bnz_taken_pc", 32'(pc), 32'd2);
    repeat (5) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 5);
    checkOutput("bnz_not_taken_pc", 32'(pc), 32'd8);
    applyStimulus(0, 0, 0, 0, 0);

    // Straight-line code across the top of the address space.
    fill_rom(K_ALU);
    rom_kind[0] = K_BNZ;
    rom_kind[1] = K_HALT;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1022);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap_pc", 32'(pc), 32'd0);
    checkOutput("wrap_err", 32'(err), 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // SW that is never acknowledged times out.
    fill_rom(K_ALU);
    rom_kind[0] = K_SW;
    applyStimulus(0, 1, 0, 0, 0);
    commits_seen = 0; reqs_seen = 0;
    repeat (9) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tmo_err", 32'(err), 32'd1);
    checkOutput("tmo_done", 32'(done), 32'd1);
    checkOutput("tmo_commits", 32'(commits_seen), 32'd0);
    checkOutput("tmo_req_cycles", 32'(reqs_seen), 32'd9);
    checkOutput("tmo_req_drop", 32'(mem_req), 32'd0);

    // Reset while waiting on memory, then restart.
    rom_kind[0] = K_LW;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_wait_req", 32'(mem_req), 32'd0);
    checkOutput("rst_wait_pc", 32'(pc), 32'd0);
    checkOutput("rst_wait_cycles", 32'(cycles), 32'd0);
    checkOutput("rst_wait_err", 32'(err), 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("restart_pc", 32'(pc), 32'd1);

    // Randomized programs and handshakes.
    for (int i = 0; i < PC_MOD; i++) begin
      r_sel = $urandom_range(0, 99);
      if (r_sel < 2)       rom_kind[i] = K_HALT;
      else if (r_sel < 17) rom_kind[i] = K_LW;
      else if (r_sel < 32) rom_kind[i] = K_SW;
      else if (r_sel < 47) rom_kind[i] = K_BNZ;
      else                 rom_kind[i] = K_ALU;
    end
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = m_active ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      r_ack = ($urandom_range(0, 9) < 4);
      r_tk  = $urandom_range(0, 1) == 1;
      applyStimulus(r_rst, r_st, r_ack, r_tk, int'($urandom_range(0, PC_MOD - 1)));
    end

    // Small instance: 3-bit PC wraps, 3-bit cycle counter saturates at 7.
    reset = 1'b0; start = 1'b0;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    checkOutput("small_wrap_pc", 32'(pc2), 32'd0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("small_pc", 32'(pc2), 32'd4);
    checkOutput("small_cycles_sat", 32'(cycles2), 32'd7);
    checkOutput("small_err", 32'(err2), 32'd0);
    checkOutput("small_commit", 32'(commit_en2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
